// File: rtl/progmem_loader.sv
// Program-memory loader: packs a byte stream little-endian into INST_W-bit words,
// holds the core off while loading, then serves instruction words combinationally.
module progmem_loader #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load_start,
    input  logic [7:0]        load_data,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded,
    output logic              core_en,
    input  logic [ADDR_W-1:0] progmem_addr,
    output logic [INST_W-1:0] progmem_data
);

    localparam int BYTES = INST_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]  byte_idx;
    logic [INST_W-1:0] pack;
    logic [INST_W-1:0] word_next;
    logic              accept;
    logic              word_done;
    logic              full;
    logic [INST_W-1:0] mem [DEPTH];

    assign load_ready = (state == LOAD) & ~load_start;
    assign accept     = load_valid & load_ready;
    assign word_done  = accept & (load_last | (byte_idx == IDX_W'(BYTES - 1)));
    // words_loaded saturates at DEPTH, so its MSB alone marks a full RAM
    assign full       = words_loaded[ADDR_W];
    assign word_next  = pack | (INST_W'(load_data) << {byte_idx, 3'b000});
    assign core_en    = en & (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load_start) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    if (accept && load_last) state_next = RUN;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_loaded <= '0;
            byte_idx     <= '0;
            pack         <= '0;
            load_err     <= 1'b0;
        end else if (load_start) begin
            words_loaded <= '0;
            byte_idx     <= '0;
            pack         <= '0;
            load_err     <= 1'b0;
        end else if (accept) begin
            if (word_done) begin
                byte_idx <= '0;
                pack     <= '0;
                if (full) begin
                    load_err <= 1'b1;
                end else begin
                    words_loaded <= words_loaded + 1'b1;
                end
            end else begin
                byte_idx <= byte_idx + 1'b1;
                pack     <= word_next;
            end
        end
    end

    // RAM has no reset; the words_loaded bound below hides stale contents
    always_ff @(posedge clk) begin
        if (word_done && !full) begin
            mem[words_loaded[ADDR_W-1:0]] <= word_next;
        end
    end

    assign progmem_data = ({1'b0, progmem_addr} < words_loaded) ? mem[progmem_addr] : '0;

endmodule

// File: tb/tb_progmem_loader.sv
// Self-checking bench for progmem_loader: random byte streams compared against a
// queue-based model of the loaded image.
module tb_progmem_loader;

    localparam int INST_W = 32;
    localparam int ADDR_W = 8;
    localparam int BYTES  = INST_W / 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b1;
    logic              load_start = 1'b0;
    logic [7:0]        load_data = '0;
    logic              load_valid = 1'b0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;
    logic              core_en;
    logic [ADDR_W-1:0] progmem_addr = '0;
    logic [INST_W-1:0] progmem_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] img[$];
    bit         got_last = 1'b0;
    int         mode = 0;   // 0 idle, 1 loading, 2 running

    progmem_loader #(.INST_W(INST_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
        .load_last(load_last), .load_ready(load_ready), .load_err(load_err),
        .words_loaded(words_loaded), .core_en(core_en),
        .progmem_addr(progmem_addr), .progmem_data(progmem_data)
    );

    always #5 clk = ~clk;

    function automatic int image_words();
        return got_last ? (img.size() + BYTES - 1) / BYTES : img.size() / BYTES;
    endfunction

    function automatic int exp_words();
        int n = image_words();
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    function automatic bit exp_err();
        return image_words() > DEPTH;
    endfunction

    function automatic logic [INST_W-1:0] exp_data(int a);
        logic [INST_W-1:0] w = '0;
        if (a >= exp_words()) return '0;
        for (int k = 0; k < BYTES; k++)
            if (a * BYTES + k < img.size()) w[8*k +: 8] = img[a * BYTES + k];
        return w;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        img.delete();
        got_last = 1'b0;
        mode = 1;
    endtask

    task automatic send(input logic [7:0] b, input bit last, output bit rdy);
        load_data  = b;
        load_valid = 1'b1;
        load_last  = last;
        #1;
        rdy = load_ready;
        cycle();
        if (rdy) begin
            img.push_back(b);
            if (last) begin
                got_last = 1'b1;
                mode = 2;
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic read_addr(input int a);
        progmem_addr = ADDR_W'(a);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (load_ready !== 1'b0) $display("FAIL reset_ready: got %0b expected 0", load_ready); else n_pass++;
        n_checks++; if (load_err !== 1'b0) $display("FAIL reset_err: got %0b expected 0", load_err); else n_pass++;
        n_checks++; if (words_loaded !== '0) $display("FAIL reset_words: got %0d expected 0", words_loaded); else n_pass++;
        n_checks++; if (core_en !== 1'b0) $display("FAIL reset_core_en: got %0b expected 0", core_en); else n_pass++;
        read_addr($urandom_range(0, DEPTH - 1));
        n_checks++; if (progmem_data !== '0) $display("FAIL reset_data: got %0h expected 0", progmem_data); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic();
        bit rdy;
        logic [7:0] seq [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_start();
        for (int i = 0; i < 7; i++) send(seq[i], 1'b0, rdy);
        n_checks++; if (core_en !== 1'b0) $display("FAIL basic_core_en_loading: got %0b expected 0", core_en); else n_pass++;
        send(seq[7], 1'b1, rdy);
        n_checks++; if (core_en !== 1'b1) $display("FAIL basic_core_en_run: got %0b expected 1", core_en); else n_pass++;
        n_checks++; if (words_loaded !== 9'd2) $display("FAIL basic_words: got %0d expected 2", words_loaded); else n_pass++;
        read_addr(0);
        n_checks++; if (progmem_data !== 32'h44332211) $display("FAIL basic_word0: got %0h expected 44332211", progmem_data); else n_pass++;
        read_addr(1);
        n_checks++; if (progmem_data !== 32'h88776655) $display("FAIL basic_word1: got %0h expected 88776655", progmem_data); else n_pass++;
        read_addr(2);
        n_checks++; if (progmem_data !== '0) $display("FAIL basic_word2_nop: got %0h expected 0", progmem_data); else n_pass++;
    endtask

    task automatic test_pad();
        bit rdy;
        do_start();
        for (int i = 1; i <= 6; i++) send(8'(i), i == 6, rdy);
        n_checks++; if (words_loaded !== 9'd2) $display("FAIL pad_words: got %0d expected 2", words_loaded); else n_pass++;
        read_addr(0);
        n_checks++; if (progmem_data !== 32'h04030201) $display("FAIL pad_word0: got %0h expected 04030201", progmem_data); else n_pass++;
        read_addr(1);
        n_checks++; if (progmem_data !== 32'h00000605) $display("FAIL pad_word1: got %0h expected 00000605", progmem_data); else n_pass++;
    endtask

    task automatic test_overflow();
        bit rdy;
        int stalls = 0;
        int total = DEPTH * BYTES + BYTES;
        do_start();
        for (int i = 0; i < total; i++) begin
            if (i == DEPTH * BYTES) begin
                n_checks++; if (load_err !== 1'b0) $display("FAIL ovf_err_early: got %0b expected 0", load_err); else n_pass++;
                n_checks++; if (words_loaded !== 9'(DEPTH)) $display("FAIL ovf_words_full: got %0d expected %0d", words_loaded, DEPTH); else n_pass++;
            end
            send(8'($urandom), i == total - 1, rdy);
            if (!rdy) stalls++;
        end
        n_checks++; if (stalls !== 0) $display("FAIL ovf_stalls: got %0d expected 0", stalls); else n_pass++;
        n_checks++; if (words_loaded !== 9'(exp_words())) $display("FAIL ovf_words: got %0d expected %0d", words_loaded, exp_words()); else n_pass++;
        n_checks++; if (load_err !== exp_err()) $display("FAIL ovf_err: got %0b expected %0b", load_err, exp_err()); else n_pass++;
        for (int j = 0; j < 6; j++) begin
            int a = (j == 0) ? DEPTH - 1 : (j == 1) ? 0 : $urandom_range(0, DEPTH - 1);
            read_addr(a);
            n_checks++; if (progmem_data !== exp_data(a)) $display("FAIL ovf_data[%0d]: got %0h expected %0h", a, progmem_data, exp_data(a)); else n_pass++;
        end
    endtask

    task automatic test_restart_gaps();
        bit rdy;
        int n;
        n_checks++; if (load_err !== 1'b1) $display("FAIL restart_err_sticky: got %0b expected 1", load_err); else n_pass++;
        do_start();
        n_checks++; if (load_err !== 1'b0) $display("FAIL restart_err_clear: got %0b expected 0", load_err); else n_pass++;
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 2)) cycle();
            send(8'($urandom), 1'b0, rdy);
        end
        n_checks++; if (words_loaded !== 9'(exp_words())) $display("FAIL gaps_words: got %0d expected %0d", words_loaded, exp_words()); else n_pass++;
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'($urandom);
        #1;
        n_checks++; if (load_ready !== 1'b0) $display("FAIL restart_ready: got %0b expected 0", load_ready); else n_pass++;
        cycle();
        load_start = 1'b0;
        load_valid = 1'b0;
        img.delete();
        got_last = 1'b0;
        n_checks++; if (words_loaded !== '0) $display("FAIL restart_words: got %0d expected 0", words_loaded); else n_pass++;
        read_addr(0);
        n_checks++; if (progmem_data !== '0) $display("FAIL restart_stale: got %0h expected 0", progmem_data); else n_pass++;
        n = $urandom_range(5, 14);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) cycle();
            send(8'($urandom), i == n - 1, rdy);
        end
        n_checks++; if (words_loaded !== 9'(exp_words())) $display("FAIL gaps_final_words: got %0d expected %0d", words_loaded, exp_words()); else n_pass++;
        for (int a = 0; a < 5; a++) begin
            read_addr(a);
            n_checks++; if (progmem_data !== exp_data(a)) $display("FAIL gaps_data[%0d]: got %0h expected %0h", a, progmem_data, exp_data(a)); else n_pass++;
        end
    endtask

    task automatic test_run_en();
        bit rdy;
        n_checks++; if (core_en !== 1'b1) $display("FAIL run_en_high: got %0b expected 1", core_en); else n_pass++;
        en = 1'b0;
        cycle();
        n_checks++; if (core_en !== 1'b0) $display("FAIL run_en_low: got %0b expected 0", core_en); else n_pass++;
        en = 1'b1;
        cycle();
        n_checks++; if (core_en !== 1'b1) $display("FAIL run_en_back: got %0b expected 1", core_en); else n_pass++;
        load_start = 1'b1;
        #1;
        n_checks++; if (core_en !== 1'b1) $display("FAIL run_start_same_cycle: got %0b expected 1", core_en); else n_pass++;
        cycle();
        load_start = 1'b0;
        img.delete();
        got_last = 1'b0;
        mode = 1;
        n_checks++; if (core_en !== 1'b0) $display("FAIL run_start_core_en: got %0b expected 0", core_en); else n_pass++;
        read_addr(0);
        n_checks++; if (progmem_data !== '0) $display("FAIL run_old_image: got %0h expected 0", progmem_data); else n_pass++;
        for (int i = 0; i < BYTES + 2; i++) send(8'($urandom), 1'b0, rdy);
        n_checks++; if (words_loaded !== 9'(exp_words())) $display("FAIL run_reload_words: got %0d expected %0d", words_loaded, exp_words()); else n_pass++;
        read_addr(0);
        n_checks++; if (progmem_data !== exp_data(0)) $display("FAIL run_reload_word0: got %0h expected %0h", progmem_data, exp_data(0)); else n_pass++;
    endtask

    task automatic test_reset_midword();
        bit rdy;
        int bad = 0;
        rst = 1'b1;
        img.delete();
        got_last = 1'b0;
        mode = 0;
        #1;
        n_checks++; if (load_ready !== 1'b0) $display("FAIL midrst_ready: got %0b expected 0", load_ready); else n_pass++;
        n_checks++; if (core_en !== 1'b0) $display("FAIL midrst_core_en: got %0b expected 0", core_en); else n_pass++;
        n_checks++; if (words_loaded !== '0) $display("FAIL midrst_words: got %0d expected 0", words_loaded); else n_pass++;
        for (int a = 0; a < DEPTH; a++) begin
            read_addr(a);
            if (progmem_data !== '0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL midrst_data_nonzero: got %0d addresses expected 0", bad); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        cycle();
        send(8'hA5, 1'b1, rdy);
        n_checks++; if (rdy !== 1'b0) $display("FAIL idle_ignores_byte: got ready %0b expected 0", rdy); else n_pass++;
        n_checks++; if (words_loaded !== 9'(exp_words())) $display("FAIL idle_words: got %0d expected %0d", words_loaded, exp_words()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pad();
        test_overflow();
        test_restart_gaps();
        test_run_en();
        test_reset_midword();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
